// File: rtl/y86_fetch_stage_pkg.sv
// y86_fetch_stage_pkg
// Shared definitions for the Y86 fetch stage: word/bus widths, icode
// constants, status codes, fetch FSM states, the IF/ID register layout and
// the instruction length table.
// Optional feature macro used by files that import this package:
// FETCH_PERF_EN (fetch/bubble performance counters).
package y86_fetch_stage_pkg;

    localparam int WORD    = 32;
    localparam int INSTBUS = 48;
    localparam int LEN_W   = 3;

    localparam logic [WORD-1:0] ZEROWORD = '0;
    localparam logic            ENABLE   = 1'b1;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVL = 4'h2;
    localparam logic [3:0] IIRMOVL = 4'h3;
    localparam logic [3:0] IRMMOVL = 4'h4;
    localparam logic [3:0] IMRMOVL = 4'h5;
    localparam logic [3:0] IOPL    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHL  = 4'hA;
    localparam logic [3:0] IPOPL   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic            valid;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [3:0]      ra;
        logic [3:0]      rb;
        logic [WORD-1:0] valc;
        logic [WORD-1:0] valp;
        logic [WORD-1:0] pc;
        stat_e           stat;
    } if_id_t;

    // Reset image differs from a bubble only in icode (halt vs nop).
    localparam if_id_t IFID_RESET = '{valid: 1'b0, icode: IHALT, ifun: 4'h0,
                                      ra: REG_NONE, rb: REG_NONE,
                                      valc: ZEROWORD, valp: ZEROWORD,
                                      pc: ZEROWORD, stat: STAT_AOK};

    localparam if_id_t IFID_BUBBLE = '{valid: 1'b0, icode: INOP, ifun: 4'h0,
                                       ra: REG_NONE, rb: REG_NONE,
                                       valc: ZEROWORD, valp: ZEROWORD,
                                       pc: ZEROWORD, stat: STAT_AOK};

    // Byte length of an instruction from its icode; unknown icodes take one
    // byte so that valP stays well defined for the INS report.
    function automatic logic [LEN_W-1:0] inst_length(input logic [3:0] icode);
        logic [LEN_W-1:0] len;
        case (icode)
            IHALT, INOP, IRET:             len = 3'd1;
            IRRMOVL, IOPL, IPUSHL, IPOPL:  len = 3'd2;
            IJXX, ICALL:                   len = 3'd5;
            IIRMOVL, IRMMOVL, IMRMOVL:     len = 3'd6;
            default:                       len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/y86_fetch_stage_if.sv
// y86_fetch_stage_if
// Bundles everything between the fetch stage and its surroundings except
// clk/rst: hazard-unit controls, the instruction-memory port, the IF/ID
// register outputs and a debug view of the fetch FSM state.
//   master : the fetch stage (drives fetch_addr_o, id_*, halted_o, state_o)
//   slave  : hazard unit / memory / decode side
// Handshake: there is no valid/ready pair; inst_i must be valid in the same
// cycle fetch_addr_o is presented, and id_valid_o marks a real instruction
// in IF/ID (0 = bubble).
// With FETCH_PERF_EN defined, perf_fetched_o / perf_bubble_o are added.
interface y86_fetch_stage_if;
    import y86_fetch_stage_pkg::*;

    logic               stall_i;
    logic               flush_i;
    logic               redirect_i;
    logic [WORD-1:0]    redirect_pc_i;
    logic [WORD-1:0]    fetch_addr_o;
    logic [INSTBUS-1:0] inst_i;
    logic               id_valid_o;
    logic [3:0]         id_icode_o;
    logic [3:0]         id_ifun_o;
    logic [3:0]         id_ra_o;
    logic [3:0]         id_rb_o;
    logic [WORD-1:0]    id_valc_o;
    logic [WORD-1:0]    id_valp_o;
    logic [WORD-1:0]    id_pc_o;
    logic [1:0]         id_stat_o;
    logic               halted_o;
    fetch_state_e       state_o;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetched_o;
    logic [31:0]        perf_bubble_o;
`endif

    modport master (
        input  stall_i, flush_i, redirect_i, redirect_pc_i, inst_i,
        output fetch_addr_o, id_valid_o, id_icode_o, id_ifun_o, id_ra_o,
               id_rb_o, id_valc_o, id_valp_o, id_pc_o, id_stat_o, halted_o,
               state_o
`ifdef FETCH_PERF_EN
        , output perf_fetched_o, perf_bubble_o
`endif
    );

    modport slave (
        output stall_i, flush_i, redirect_i, redirect_pc_i, inst_i,
        input  fetch_addr_o, id_valid_o, id_icode_o, id_ifun_o, id_ra_o,
               id_rb_o, id_valc_o, id_valp_o, id_pc_o, id_stat_o, halted_o,
               state_o
`ifdef FETCH_PERF_EN
        , input perf_fetched_o, perf_bubble_o
`endif
    );

endinterface

// File: rtl/y86_predecode.sv
// y86_predecode
// Pure combinational predecode of the 6-byte big-endian window at pc_i.
// Ports:
//   inst_i  : bytes pc..pc+5, inst_i[47:40] = byte0
//   pc_i    : address of byte0
//   icode_o/ifun_o/ra_o/rb_o : decoded fields (ra/rb = REG_NONE without a
//             register byte)
//   valc_o  : little-endian constant word (0 when absent)
//   valp_o  : pc_i + length (wraps at 32 bits)
//   stat_o  : AOK / HLT / ADR / INS, ADR taking precedence
module y86_predecode
    import y86_fetch_stage_pkg::*;
#(
    parameter int INSTMEM_BYTES = 1024
) (
    input  logic [INSTBUS-1:0] inst_i,
    input  logic [WORD-1:0]    pc_i,
    output logic [3:0]         icode_o,
    output logic [3:0]         ifun_o,
    output logic [3:0]         ra_o,
    output logic [3:0]         rb_o,
    output logic [WORD-1:0]    valc_o,
    output logic [WORD-1:0]    valp_o,
    output stat_e              stat_o
);

    localparam logic [WORD:0] INSTMEM_LIMIT = {1'b0, INSTMEM_BYTES[WORD-1:0]};

    logic [LEN_W-1:0] len;
    logic             has_reg;
    logic [WORD:0]    last_byte;
    logic             adr_err;

    assign icode_o = inst_i[47:44];
    assign ifun_o  = inst_i[43:40];
    assign len     = inst_length(icode_o);
    assign has_reg = (len == 3'd2) || (len == 3'd6);

    assign ra_o = has_reg ? inst_i[39:36] : REG_NONE;
    assign rb_o = has_reg ? inst_i[35:32] : REG_NONE;

    always_comb begin
        valc_o = ZEROWORD;
        if (len == 3'd6) begin
            valc_o = {inst_i[7:0], inst_i[15:8], inst_i[23:16], inst_i[31:24]};
        end else if (len == 3'd5) begin
            valc_o = {inst_i[15:8], inst_i[23:16], inst_i[31:24], inst_i[39:32]};
        end
    end

    assign valp_o = pc_i + {{(WORD-LEN_W){1'b0}}, len};

    // 33-bit so a window that runs past 2^32 still reads as out of range.
    assign last_byte = {1'b0, pc_i} + {{(WORD-LEN_W+1){1'b0}}, len} - {{WORD{1'b0}}, 1'b1};
    assign adr_err   = (last_byte >= INSTMEM_LIMIT);

    always_comb begin
        stat_o = STAT_AOK;
        if (adr_err) begin
            stat_o = STAT_ADR;
        end else if (icode_o > IPOPL) begin
            stat_o = STAT_INS;
        end else if (icode_o == IHALT) begin
            stat_o = STAT_HLT;
        end
    end

endmodule

// File: rtl/y86_fetch_stage.sv
// y86_fetch_stage
// Y86 fetch stage: owns the PC, presents it as fetch_addr_o, predecodes the
// returned window and loads the IF/ID register one cycle later.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   fif  : y86_fetch_stage_if.master (controls, imem port, IF/ID outputs,
//          halted_o, state_o debug view)
// Cycle priority: rst > redirect_i > stall_i > normal fetch.
// FSM: RUN fetches and advances the PC; RET_WAIT holds the PC on the ret and
// issues bubbles until redirect_i; HALTED holds the PC on the faulting/halt
// instruction and issues bubbles until rst.
// Optional macro FETCH_PERF_EN adds perf_fetched_o / perf_bubble_o.
module y86_fetch_stage
    import y86_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          INSTMEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    y86_fetch_stage_if.master  fif
);

    fetch_state_e    state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    if_id_t          ifid_q, ifid_d;

    logic [3:0]      pd_icode, pd_ifun, pd_ra, pd_rb;
    logic [WORD-1:0] pd_valc, pd_valp, pred_pc;
    stat_e           pd_stat;

    logic            redirect_take;
    logic            load_bubble;
    logic            load_inst;

    y86_predecode #(.INSTMEM_BYTES(INSTMEM_BYTES)) u_predecode (
        .inst_i  (fif.inst_i),
        .pc_i    (pc_q),
        .icode_o (pd_icode),
        .ifun_o  (pd_ifun),
        .ra_o    (pd_ra),
        .rb_o    (pd_rb),
        .valc_o  (pd_valc),
        .valp_o  (pd_valp),
        .stat_o  (pd_stat)
    );

    assign pred_pc       = ((pd_icode == IJXX) || (pd_icode == ICALL)) ? pd_valc : pd_valp;
    assign redirect_take = fif.redirect_i && (state_q != ST_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            ifid_q  <= IFID_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_d      = ifid_q;
        load_bubble = 1'b0;
        load_inst   = 1'b0;

        if (redirect_take) begin
            pc_d        = fif.redirect_pc_i;
            state_d     = ST_RUN;
            load_bubble = 1'b1;
        end else if (fif.stall_i) begin
            load_bubble = fif.flush_i;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Halt/error and ret leave the PC on the instruction
                    // itself; everything else follows the prediction.
                    if (pd_stat != STAT_AOK) begin
                        state_d = ST_HALTED;
                    end else if (pd_icode == IRET) begin
                        state_d = ST_RET_WAIT;
                    end else begin
                        pc_d = pred_pc;
                    end
                    load_bubble = fif.flush_i;
                    load_inst   = !fif.flush_i;
                end
                default: begin
                    load_bubble = 1'b1;
                end
            endcase
        end

        if (load_bubble) begin
            ifid_d = IFID_BUBBLE;
        end else if (load_inst) begin
            ifid_d = '{valid: ENABLE, icode: pd_icode, ifun: pd_ifun,
                       ra: pd_ra, rb: pd_rb, valc: pd_valc, valp: pd_valp,
                       pc: pc_q, stat: pd_stat};
        end
    end

    assign fif.fetch_addr_o = pc_q;
    assign fif.id_valid_o   = ifid_q.valid;
    assign fif.id_icode_o   = ifid_q.icode;
    assign fif.id_ifun_o    = ifid_q.ifun;
    assign fif.id_ra_o      = ifid_q.ra;
    assign fif.id_rb_o      = ifid_q.rb;
    assign fif.id_valc_o    = ifid_q.valc;
    assign fif.id_valp_o    = ifid_q.valp;
    assign fif.id_pc_o      = ifid_q.pc;
    assign fif.id_stat_o    = ifid_q.stat;
    assign fif.halted_o     = (state_q == ST_HALTED);
    assign fif.state_o      = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_bubble_q;
    logic        count_bubble;

    // Bubbles forced while stalled are not counted.
    assign count_bubble = load_bubble && (redirect_take || !fif.stall_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubble_q  <= '0;
        end else begin
            if (load_inst) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (count_bubble) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign fif.perf_fetched_o = perf_fetched_q;
    assign fif.perf_bubble_o  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_y86_fetch_stage.sv
// tb_y86_fetch_stage
// Bench for y86_fetch_stage: byte-array instruction memory, reference model
// of the fetch rules, expected-queue scoreboard popped by a monitor on every
// falling edge, directed program followed by randomized control traffic.
module tb_y86_fetch_stage;
    import y86_fetch_stage_pkg::*;

    localparam int MEM_BYTES = 1024;
    localparam int EXP_W     = 148;

    logic clk = 1'b0;
    logic rst = 1'b0;

    y86_fetch_stage_if fif();

    y86_fetch_stage #(.RESET_PC(32'h0000_0000), .INSTMEM_BYTES(MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    always #5 clk = ~clk;

    logic [7:0]       mem [0:MEM_BYTES-1];
    logic [EXP_W-1:0] exp_q [$];
    logic [63:0]      perf_q [$];
    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_pc;
    int          m_state;   // 0 run, 1 waiting for ret target, 2 halted
    logic        m_valid;
    logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
    logic [31:0] m_valc, m_valp, m_idpc;
    logic [1:0]  m_stat;
    logic [31:0] m_fetched, m_bubble;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (a < MEM_BYTES) return mem[a[9:0]];
        return 8'h00;
    endfunction

    function automatic logic [47:0] window(input logic [31:0] a);
        logic [47:0] w;
        for (int i = 0; i < 6; i++) w[47-8*i -: 8] = rd(a + 32'(i));
        return w;
    endfunction

    function automatic int len_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:         return 1;
            4'h2, 4'h6, 4'hA, 4'hB:   return 2;
            4'h7, 4'h8:               return 5;
            4'h3, 4'h4, 4'h5:         return 6;
            default:                  return 1;
        endcase
    endfunction

    task automatic set_bubble();
        m_valid = 1'b0; m_icode = 4'h1; m_ifun = 4'h0; m_ra = 4'hF; m_rb = 4'hF;
        m_valc = 32'h0; m_valp = 32'h0; m_idpc = 32'h0; m_stat = 2'd0;
    endtask

    task automatic model_reset();
        set_bubble();
        m_icode = 4'h0;
        m_pc = 32'h0; m_state = 0; m_fetched = 32'h0; m_bubble = 32'h0;
    endtask

    task automatic push_exp();
        logic halted_e;
        halted_e = (m_state == 2);
        exp_q.push_back({m_valid, m_icode, m_ifun, m_ra, m_rb, m_valc, m_valp,
                         m_idpc, m_stat, halted_e, m_pc});
        perf_q.push_back({m_fetched, m_bubble});
    endtask

    // One clock of the fetch rules, written from the instruction table.
    task automatic model_step(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        logic [7:0]  b [6];
        logic [3:0]  ic;
        logic [31:0] vc, vp;
        logic [63:0] end_addr;
        logic [1:0]  st;
        int          len, off;
        for (int i = 0; i < 6; i++) b[i] = rd(m_pc + 32'(i));
        ic  = b[0][7:4];
        len = len_of(ic);
        vc  = 32'h0;
        if (len >= 5) begin
            off = (len == 6) ? 2 : 1;
            for (int k = 0; k < 4; k++) vc = vc | (32'(b[off+k]) << (8*k));
        end
        vp = m_pc + 32'(len);
        end_addr = {32'h0, m_pc} + 64'(len);
        if (end_addr > 64'(MEM_BYTES)) st = 2'd2;
        else if (ic >= 4'hC)           st = 2'd3;
        else if (ic == 4'h0)           st = 2'd1;
        else                           st = 2'd0;

        if (r && m_state != 2) begin
            m_pc = rpc; m_state = 0; set_bubble(); m_bubble++;
        end else if (s) begin
            if (f) set_bubble();
        end else if (m_state == 0) begin
            if (f) begin
                set_bubble(); m_bubble++;
            end else begin
                m_valid = 1'b1; m_icode = ic; m_ifun = b[0][3:0];
                m_ra = (len == 2 || len == 6) ? b[1][7:4] : 4'hF;
                m_rb = (len == 2 || len == 6) ? b[1][3:0] : 4'hF;
                m_valc = vc; m_valp = vp; m_idpc = m_pc; m_stat = st; m_fetched++;
            end
            if (st != 2'd0)       m_state = 2;
            else if (ic == 4'h9)  m_state = 1;
            else                  m_pc = (ic == 4'h7 || ic == 4'h8) ? vc : vp;
        end else begin
            set_bubble(); m_bubble++;
        end
    endtask

    // monitor: compares whatever the DUT shows against the oldest expectation
    initial begin
        logic [EXP_W-1:0] e;
        logic [63:0]      p;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                p = perf_q.pop_front();
                check("id_valid", 32'(fif.id_valid_o), 32'(e[147]));
                check("id_icode", 32'(fif.id_icode_o), 32'(e[146:143]));
                check("id_ifun",  32'(fif.id_ifun_o),  32'(e[142:139]));
                check("id_ra",    32'(fif.id_ra_o),    32'(e[138:135]));
                check("id_rb",    32'(fif.id_rb_o),    32'(e[134:131]));
                check("id_valc",  fif.id_valc_o,       e[130:99]);
                check("id_valp",  fif.id_valp_o,       e[98:67]);
                check("id_pc",    fif.id_pc_o,         e[66:35]);
                check("id_stat",  32'(fif.id_stat_o),  32'(e[34:33]));
                check("halted",   32'(fif.halted_o),   32'(e[32]));
                check("fetch_addr", fif.fetch_addr_o,  e[31:0]);
`ifdef FETCH_PERF_EN
                check("perf_fetched", fif.perf_fetched_o, p[63:32]);
                check("perf_bubble",  fif.perf_bubble_o,  p[31:0]);
`else
                p = 64'h0;
`endif
            end
        end
    end

    // Called in the low phase; returns in the low phase after the compare edge.
    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rpc);
        fif.stall_i = s; fif.flush_i = f; fif.redirect_i = r; fif.redirect_pc_i = rpc;
        fif.inst_i = window(fif.fetch_addr_o);
        @(posedge clk);
        #1;
        model_step(s, f, r, rpc);
        push_exp();
        @(negedge clk);
        #1;
    endtask

    // Asserted between edges, so outputs must change without a clock.
    task automatic do_reset();
        fif.stall_i = 1'b0; fif.flush_i = 1'b0; fif.redirect_i = 1'b0;
        fif.redirect_pc_i = 32'h0;
        rst = 1'b1;
        #1;
        check("async_rst_fetch_addr", fif.fetch_addr_o, 32'h0);
        check("async_rst_valid", 32'(fif.id_valid_o), 32'h0);
        check("async_rst_halted", 32'(fif.halted_o), 32'h0);
        model_reset();
        push_exp();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic build_random_program();
        int a = 0;
        int pick, len;
        logic [3:0] ic;
        logic [31:0] c;
        logic [3:0] ops [10];
        ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB};
        while (a < MEM_BYTES) begin
            pick = $urandom_range(0, 99);
            if (pick < 3)       ic = 4'h0;
            else if (pick < 6)  ic = 4'(12 + $urandom_range(0, 3));
            else if (pick < 10) ic = 4'h9;
            else                ic = ops[$urandom_range(0, 9)];
            len = len_of(ic);
            c = (ic == 4'h7 || ic == 4'h8) ? 32'($urandom_range(0, MEM_BYTES - 8)) : $urandom;
            for (int i = 0; i < len; i++) begin
                if (a + i < MEM_BYTES) begin
                    if (i == 0)                      mem[a] = {ic, 4'($urandom_range(0, 6))};
                    else if (i == 1 && len != 5)     mem[a+i] = 8'($urandom);
                    else                             mem[a+i] = 8'(c >> (8 * (i - ((len == 5) ? 1 : 2))));
                end
            end
            a += len;
        end
    endtask

    initial begin
        int halt_cnt;
        logic [31:0] rpc;
        logic s, f, r;
        fif.stall_i = 1'b0; fif.flush_i = 1'b0; fif.redirect_i = 1'b0;
        fif.redirect_pc_i = 32'h0; fif.inst_i = 48'h0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h10;
        // irmovl $10,%edx ; jmp 0x20
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = 48'h30F2_0A00_0000;
        {mem[6], mem[7], mem[8], mem[9], mem[10]} = 40'h70_2000_0000;
        mem[11] = 8'h10;
        {mem[12], mem[13], mem[14], mem[15], mem[16]} = 40'h70_2000_0000;
        mem[32] = 8'h90;
        {mem[64], mem[65], mem[66], mem[67]} = 32'h6012_2034;
        {mem[68], mem[69], mem[70], mem[71], mem[72], mem[73]} = 48'h30F3_4433_2211;
        mem[74] = 8'h10;
        mem[75] = 8'h00;
        mem[96] = 8'hF0;
        mem[1022] = 8'h30;
        mem[1023] = 8'hF2;

        #1;
        do_reset();

        step(0, 0, 0, 0);
        check("irmovl_valc", fif.id_valc_o, 32'h0000_000A);
        check("irmovl_rb", 32'(fif.id_rb_o), 32'h2);
        check("irmovl_fetch", fif.fetch_addr_o, 32'h6);
        step(0, 0, 0, 0);
        check("jxx_valp", fif.id_valp_o, 32'h0B);
        check("jxx_fetch", fif.fetch_addr_o, 32'h20);
        step(0, 0, 1, 32'h0B);
        check("redirect_bubble", 32'(fif.id_valid_o), 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);                       // ret at 0x20
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check("ret_wait_fetch", fif.fetch_addr_o, 32'h20);
        step(0, 0, 1, 32'h40);
        check("ret_resolved_state", 32'(fif.state_o), 32'(ST_RUN));
        step(0, 0, 0, 0);                       // addl
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("stall_hold_fetch", fif.fetch_addr_o, 32'h42);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);                       // irmovl at 0x44
        check("irmovl2_valc", fif.id_valc_o, 32'h1122_3344);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);                       // halt
        check("halt_stat", 32'(fif.id_stat_o), 32'(STAT_HLT));
        check("halt_flag", 32'(fif.halted_o), 32'h1);
        step(0, 0, 1, 32'h10);
        step(0, 0, 0, 0);
        check("halted_frozen", fif.fetch_addr_o, 32'h4B);

        do_reset();
        step(0, 0, 1, 32'h60);
        step(0, 0, 0, 0);
        check("ins_stat", 32'(fif.id_stat_o), 32'(STAT_INS));
        step(0, 0, 0, 0);

        do_reset();
        step(0, 0, 1, MEM_BYTES - 2);
        step(0, 0, 0, 0);
        check("adr_stat", 32'(fif.id_stat_o), 32'(STAT_ADR));
        step(0, 0, 1, 32'h0);

        do_reset();
        step(0, 0, 1, 32'h20);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        do_reset();                             // mid-cycle reset while waiting on ret

        build_random_program();
        halt_cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 99) < 8);
            s = ($urandom_range(0, 99) < 15);
            f = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 10) rpc = 32'($urandom_range(MEM_BYTES - 6, MEM_BYTES + 3));
            else                            rpc = 32'($urandom_range(0, MEM_BYTES - 1));
            step(s, f, r, rpc);
            if (m_state == 2) halt_cnt++;
            if (halt_cnt >= 3) begin
                halt_cnt = 0;
                do_reset();
                step(0, 0, 1, 32'($urandom_range(0, MEM_BYTES - 1)));
            end
        end

        repeat (2) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y86_fetch_stage.md
Name: y86_fetch_stage

Overview:
Fetch stage of the Y86 pipeline: owns the PC, drives the instruction-memory fetch address, and consumes the 48-bit big-endian byte window returned combinationally for that address. Predecodes icode/ifun/rA/rB/valC, computes instruction length and valP, predicts next PC, and registers the result into the IF/ID pipeline register with stall, flush and redirect control from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
INSTMEM_BYTES, 1024, instruction memory size; fetches whose last byte exceeds it get ADR status

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  hold PC and IF/ID register
flush_i  in  1  load bubble into IF/ID register
redirect_i  in  1  mispredict/ret resolution; load redirect_pc_i into PC
redirect_pc_i  in  32  corrected PC
fetch_addr_o  out  32  byte address to instruction memory (= PC)
inst_i  in  48  bytes addr..addr+5; inst_i[47:40] = byte0
id_valid_o  out  1  IF/ID holds a real instruction
id_icode_o  out  4  byte0[7:4]
id_ifun_o  out  4  byte0[3:0]
id_ra_o  out  4  byte1[7:4], 4'hF if no register byte
id_rb_o  out  4  byte1[3:0], 4'hF if no register byte
id_valc_o  out  32  constant word, little-endian assembled
id_valp_o  out  32  PC + length
id_pc_o  out  32  PC of this instruction
id_stat_o  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS
halted_o  out  1  fetch stopped after halt/error

Behaviour:
- Reset (async): PC=RESET_PC, state RUN, id_valid_o=0, all id_* fields 0, id_ra/rb=4'hF, id_stat_o=AOK, halted_o=0.
- fetch_addr_o = PC combinationally; predecode is combinational on inst_i; one-cycle latency to id_* outputs.
- Length by icode: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 5; 3,4,5 -> 6; C..F -> 1 with stat INS.
- valC: length 6 -> {inst_i[7:0],inst_i[15:8],inst_i[23:16],inst_i[31:24]}; length 5 -> {inst_i[15:8],inst_i[23:16],inst_i[31:24],inst_i[39:32]}; else 0.
- valP = PC + length, 32-bit wrap, no carry out.
- ADR if PC + length - 1 >= INSTMEM_BYTES (compute in 33 bits); ADR overrides INS; halt gives HLT.
- Predicted next PC: jXX/call -> valC; otherwise valP.
- States: RUN (fetch, advance PC); RET_WAIT (after ret fetched: PC held, IF/ID loads bubbles until redirect_i); HALTED (entered after fetching HLT/ADR/INS instruction: PC frozen, bubbles, halted_o=1; only rst exits).
- Priority each cycle: rst > redirect_i > stall_i > normal.
- redirect_i: PC <= redirect_pc_i; state RET_WAIT -> RUN; IF/ID loads bubble (redirect implies flush). Redirect in HALTED is ignored.
- flush_i alone: IF/ID bubble; PC still advances unless stall_i.
- stall_i (no redirect): PC, state and IF/ID held unchanged; flush_i with stall_i -> IF/ID bubble, PC held.
- Bubble = id_valid_o 0, icode 1 (nop), ra/rb F, valC/valP/pc 0, stat AOK.

Optional Feature:
FETCH_PERF_EN: adds outputs perf_fetched_o[31:0] (count of non-bubble IF/ID loads) and perf_bubble_o[31:0] (count of bubble loads, excluding stall cycles); both reset to 0, wrap at 2^32. Without it, ports and counters absent; core behaviour identical.

Decomposition:
- Shared package/defines: icode constants (IHALT..IPOPL), stat codes, REG_NONE=4'hF, state encodings, length table widths; reuse WORD/INSTBUS/ZEROWORD/ENABLE.
- One sub-module: y86_predecode (pure combinational: icode/ifun/ra/rb/valC/length/stat from inst_i and PC).

Test Plan:
- Reset, inst bytes 30 F2 0A 00 00 00 at PC 0 (irmovl $10,%edx) -> next cycle id_valid 1, ra F, rb 2, valC 0x0000000A, valP 6, fetch_addr 6.
- jXX 70 20 00 00 00 at PC 6 -> valC 0x20, valP 0x0B, fetch_addr 0x20 next cycle; then redirect_i=1, redirect_pc_i=0x0B -> fetch_addr 0x0B, IF/ID bubble.
- ret 90 at PC 0x20 -> bubbles and fetch_addr held at 0x20 for 3 cycles; redirect_pc_i=0x40 -> fetch_addr 0x40, state RUN.
- stall_i high 2 cycles mid-stream -> fetch_addr and all id_* unchanged; stall_i with flush_i -> id_valid 0, PC held.
- halt 00 -> id_stat HLT, halted_o 1, PC frozen; byte F0 -> INS; PC=INSTMEM_BYTES-2 with irmovl -> ADR; redirect ignored until rst.
- Async rst asserted mid-cycle in RET_WAIT -> immediate PC=RESET_PC, id_valid 0, halted_o 0.
